fifo_wr_arbiter: RTL and testbench

- Shares one 8-bit synchronous FIFO write port among NREQ producers.
- Round-robin arbitration with bounded burst tenure: a granted producer keeps the port for up to BURST beats, then the grant rotates.
- Sits directly in front of the FIFO. Drives its we and data_in, and honours its full flag. Read side of the FIFO is untouched.

---
 rtl/fifo_arb_pkg.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 45 ++++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE arbitrates (one bubble), XFER moves beats for the holder.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Default configuration of the arbiter.
    localparam int NREQ_DEF  = 4;
    localparam int BURST_DEF = 4;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a beat counter that must be able to hold the value b.
    function automatic int cnt_w(input int b);
        return $clog2(b) + 1;
    endfunction

    // Grant-index and beat-count widths for the default configuration.
    localparam int GW_DEF = idx_w(NREQ_DEF);
    localparam int CW_DEF = cnt_w(BURST_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_grant, wrapping modulo NREQ (NREQ need not be a power of two).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int GW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic            any,
    output logic [GW-1:0]   winner
);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] masked;
    logic              found;

    // Duplicate the request vector and drop every lower-copy bit at or below
    // last_grant; the upper copy stays intact and supplies the wrap-around.
    always_comb begin
        dbl    = {req, req};
        masked = dbl;
        for (int i = 0; i < NREQ; i++) begin
            if (i <= int'(last_grant)) begin
                masked[i] = 1'b0;
            end
        end
    end

    // Lowest set bit of the masked vector wins; positions in the upper copy
    // are folded back by an explicit compare-and-subtract.
    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < 2*NREQ; i++) begin
            if (!found && masked[i]) begin
                found  = 1'b1;
                winner = (i >= NREQ) ? GW'(i - NREQ) : GW'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one synchronous FIFO write port among NREQ producers with
// round-robin arbitration and at most BURST beats per grant tenure.
// Handshake: a beat moves on req_valid[g] & req_ready[g]; the holder keeps
// data stable while valid & !ready, and a full FIFO only stalls, never rotates.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DW    = 8,
    parameter int BURST = BURST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      fifo_we,
    output logic [DW-1:0]             fifo_data_in,
    input  logic                      fifo_full,
    output logic [idx_w(NREQ)-1:0]    grant_id,
    output logic                      busy,
    output logic [cnt_w(BURST)-1:0]   beat_cnt
);

    localparam int GW = idx_w(NREQ);
    localparam int CW = cnt_w(BURST);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
    localparam logic [GW-1:0] LAST_REQ  = GW'(NREQ - 1);

    arb_state_t     state;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  winner;
    logic           any;
    logic           g_valid;
    logic [DW-1:0]  g_data;
    logic           port_open;
    logic           accept;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (any),
        .winner     (winner)
    );

    // Select the grant holder's valid and data.
    always_comb begin
        g_valid = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GW'(i) == grant_id) begin
                g_valid = req_valid[i];
                g_data  = req_data[i*DW +: DW];
            end
        end
    end

    // The port is open only while transferring, not full and not in reset,
    // so a beat offered during a reset cycle is never written.
    assign port_open = (state == XFER) && !fifo_full && !rst;
    assign accept    = port_open && g_valid;
    assign fifo_we   = accept;
    assign busy      = (state == XFER);

    // Ready goes only to the holder; every other bit stays low.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GW'(i) == grant_id) begin
                req_ready[i] = port_open;
            end
        end
    end

    // Write data follows the holder in XFER and is zero in IDLE.
    always_comb begin
        fifo_data_in = '0;
        if (state == XFER) begin
            fifo_data_in = g_data;
        end
    end

    // Arbitration FSM with grant, rotation pointer and tenure beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= LAST_REQ;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grant_id   <= winner;
                        last_grant <= winner;
                        beat_cnt   <= '0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (!g_valid) begin
                        state <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: scoreboard of expected FIFO writes
// ({grant_id, data}) popped by a monitor, plus per-cycle directed checks.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int W = GW_DEF + 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // ---------------- main DUT (NREQ=4, BURST=4) ----------------
    logic [3:0]         req_valid = '0;
    logic [31:0]        req_data  = '0;
    logic               fifo_full = 1'b0;
    logic [3:0]         req_ready;
    logic               fifo_we;
    logic [7:0]         fifo_data_in;
    logic [GW_DEF-1:0]  grant_id;
    logic               busy;
    logic [CW_DEF-1:0]  beat_cnt;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_we      (fifo_we),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy),
        .beat_cnt     (beat_cnt)
    );

    // ---------------- second DUT (NREQ=3, BURST=1) ----------------
    logic [2:0]  r3_valid = '0;
    logic [23:0] r3_data  = '0;
    logic        full3    = 1'b0;
    logic [2:0]  r3_ready;
    logic        we3;
    logic [7:0]  dout3;
    logic [1:0]  gid3;
    logic        busy3;
    logic [0:0]  cnt3;

    fifo_wr_arbiter #(.NREQ(3), .DW(8), .BURST(1)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (r3_valid),
        .req_data     (r3_data),
        .req_ready    (r3_ready),
        .fifo_we      (we3),
        .fifo_data_in (dout3),
        .fifo_full    (full3),
        .grant_id     (gid3),
        .busy         (busy3),
        .beat_cnt     (cnt3)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp3_q[$];
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every FIFO write; protocol checks each cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_en) begin
            chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            chk("no_write_full", 32'(fifo_we & fifo_full), 32'd0);
            if (fifo_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got write %0h, expected no write",
                             {grant_id, fifo_data_in});
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_write", 32'({grant_id, fifo_data_in}), 32'(e));
                end
            end
            chk("ready3_onehot", 32'($onehot0(r3_ready)), 32'd1);
            if (we3) begin
                if (exp3_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb3_unexpected: got write %0h, expected no write",
                             {gid3, dout3});
                end else begin
                    e = exp3_q.pop_front();
                    chk("sb3_write", 32'({gid3, dout3}), 32'(e));
                end
            end
        end
    end

    // ---------------- producer model and driver ----------------
    int         rem[4];
    logic [7:0] cur[4];
    logic [7:0] inc[4];

    logic               s_we;
    logic               s_busy;
    logic [3:0]         s_ready;
    logic [GW_DEF-1:0]  s_gid;
    logic [CW_DEF-1:0]  s_cnt;
    logic [7:0]         s_dout;

    // One clock cycle: drive inputs, snapshot outputs mid-cycle, retire accepted beats.
    task automatic step(input logic full, input logic r);
        logic [3:0] acc;
        rst       = r;
        fifo_full = full;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]         = (rem[i] != 0);
            req_data[i*8 +: 8]   = cur[i];
        end
        @(negedge clk);
        s_we    = fifo_we;
        s_busy  = busy;
        s_ready = req_ready;
        s_gid   = grant_id;
        s_cnt   = beat_cnt;
        s_dout  = fifo_data_in;
        acc     = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                rem[i] = rem[i] - 1;
                cur[i] = cur[i] + inc[i];
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            cur[i] = 8'h00;
            inc[i] = 8'h00;
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_we", 32'(s_we), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_gid", 32'(s_gid), 32'd0);
        chk("rst_cnt", 32'(s_cnt), 32'd0);
        chk("rst_dout", 32'(s_dout), 32'd0);
        mon_en = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [9:0] pat;
        int nwe;

        // Test 1: sole requester 0, six beats 0x11..0x16.
        do_reset();
        rem[0] = 6; cur[0] = 8'h11; inc[0] = 8'h01;
        for (int k = 0; k < 6; k++) exp_q.push_back({2'd0, 8'(8'h11 + k)});
        pat = 10'b0011011110;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0);
            chk("t1_we_pattern", 32'(s_we), 32'(pat[c]));
        end
        chk("t1_drain", 32'(exp_q.size()), 32'd0);

        // Test 2: all four stream their index; 4 beats each, one bubble per tenure.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rem[i] = 8; cur[i] = 8'(i); inc[i] = 8'h00;
        end
        for (int rep = 0; rep < 2; rep++)
            for (int g = 0; g < 4; g++)
                for (int k = 0; k < 4; k++) exp_q.push_back({2'(g), 8'(g)});
        nwe = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 1'b0);
            chk("t2_we_pattern", 32'(s_we), 32'((c % 5) != 0));
            if (s_we) nwe++;
        end
        chk("t2_writes", 32'(nwe), 32'd32);
        chk("t2_drain", 32'(exp_q.size()), 32'd0);

        // Test 3: requester 2 stalls on full for 5 cycles after 2 beats, then rotates to 3.
        do_reset();
        rem[2] = 4; cur[2] = 8'h20; inc[2] = 8'h01;
        rem[3] = 1; cur[3] = 8'h30; inc[3] = 8'h01;
        for (int k = 0; k < 4; k++) exp_q.push_back({2'd2, 8'(8'h20 + k)});
        exp_q.push_back({2'd3, 8'h30});
        for (int c = 0; c < 13; c++) begin
            step((c >= 3) && (c <= 7), 1'b0);
            if ((c >= 3) && (c <= 7)) begin
                chk("t3_stall_we", 32'(s_we), 32'd0);
                chk("t3_stall_ready", 32'(s_ready), 32'd0);
                chk("t3_stall_cnt", 32'(s_cnt), 32'd2);
                chk("t3_stall_gid", 32'(s_gid), 32'd2);
                chk("t3_stall_busy", 32'(s_busy), 32'd1);
            end
        end
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        // Test 4: requester 1 releases after one beat; search resumes at 2 and finds 3.
        do_reset();
        rem[1] = 1; cur[1] = 8'h41; inc[1] = 8'h01;
        rem[3] = 2; cur[3] = 8'h61; inc[3] = 8'h01;
        exp_q.push_back({2'd1, 8'h41});
        exp_q.push_back({2'd3, 8'h61});
        exp_q.push_back({2'd3, 8'h62});
        exp_q.push_back({2'd0, 8'h50});
        for (int c = 0; c < 11; c++) begin
            if (c == 2) begin
                rem[0] = 1; cur[0] = 8'h50; inc[0] = 8'h01;
            end
            step(1'b0, 1'b0);
            if (c == 2) begin
                chk("t4_release_busy", 32'(s_busy), 32'd1);
                chk("t4_release_we", 32'(s_we), 32'd0);
            end
            if (c == 3) chk("t4_idle_busy", 32'(s_busy), 32'd0);
            if (c == 4) chk("t4_next_gid", 32'(s_gid), 32'd3);
        end
        chk("t4_drain", 32'(exp_q.size()), 32'd0);

        // Test 5: reset at beat 2 with valid high; nothing written, requester 0 wins again.
        do_reset();
        rem[0] = 8; cur[0] = 8'h70; inc[0] = 8'h01;
        for (int k = 0; k < 6; k++) exp_q.push_back({2'd0, 8'(8'h70 + k)});
        exp_q.push_back({2'd1, 8'h80});
        exp_q.push_back({2'd0, 8'h76});
        exp_q.push_back({2'd0, 8'h77});
        for (int c = 0; c < 17; c++) begin
            if (c == 4) begin
                rem[1] = 1; cur[1] = 8'h80; inc[1] = 8'h01;
            end
            step(1'b0, c == 3);
            if (c == 3) begin
                chk("t5_rst_cnt_before", 32'(s_cnt), 32'd2);
                chk("t5_rst_we", 32'(s_we), 32'd0);
                chk("t5_rst_ready", 32'(s_ready), 32'd0);
            end
            if (c == 4) chk("t5_after_busy", 32'(s_busy), 32'd0);
            if (c == 5) chk("t5_first_gid", 32'(s_gid), 32'd0);
        end
        chk("t5_drain", 32'(exp_q.size()), 32'd0);

        // Test 6: NREQ=3, BURST=1, all valid; grants 0,1,2,0 with one write each.
        r3_valid = 3'b111;
        r3_data  = {8'hA2, 8'hA1, 8'hA0};
        exp3_q.push_back({2'd0, 8'hA0});
        exp3_q.push_back({2'd1, 8'hA1});
        exp3_q.push_back({2'd2, 8'hA2});
        exp3_q.push_back({2'd0, 8'hA0});
        nwe = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t6_we_pattern", 32'(we3), 32'((c % 2) == 1));
            @(posedge clk);
            #1;
        end
        r3_valid = 3'b000;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t6_drain", 32'(exp3_q.size()), 32'd0);
        chk("t6_idle_busy", 32'(busy3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
